// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch sequencing controller.
package stopwatch_pkg;

  localparam int unsigned SEC_W   = 6;
  localparam int unsigned SEC_MAX = 59;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    OVF   = 2'd3
  } state_t;

  // States in which elapsed time is live (minutes advance, laps accepted).
  function automatic logic is_active(input state_t s);
    return (s == RUN) || (s == PAUSE);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick per CLK_DIV running cycles; holds the
// partial count whenever run is low so a pause keeps the fractional second.
module tick_prescaler #(
  parameter int unsigned CLK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] TERM = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             at_term;

  assign at_term = (div_cnt == TERM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      tick <= run && at_term;
      if (clr) begin
        div_cnt <= '0;
      end else if (run) begin
        div_cnt <= at_term ? '0 : div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Start/pause/clear sequencer for a 0-59 seconds counter: drives its enable
// and clear, extends it with a minutes register and captures lap snapshots.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_DIV = 50000000,
  parameter int unsigned MIN_W   = 8,
  parameter int unsigned MAX_MIN = 99
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_stop,
  input  logic             clear,
  input  logic             lap,
  input  logic [SEC_W-1:0] seconds,
  input  logic             sec_tick,
  output logic             cnt_en,
  output logic             cnt_rst_n,
  output logic [MIN_W-1:0] minutes,
  output logic [SEC_W-1:0] lap_seconds,
  output logic [MIN_W-1:0] lap_minutes,
  output logic             lap_valid,
  output logic             running,
  output logic             ovf
);

  state_t           state, state_d;
  logic [MIN_W-1:0] minutes_d, lap_minutes_d, min_inc;
  logic [SEC_W-1:0] lap_seconds_d;
  logic             lap_valid_d, ovf_d;
  logic             at_max, live, run_c, idle_c;

  // Prescaler only advances while RUN persists into the next cycle, so a
  // pause or overflow landing on the terminal count suppresses that tick.
  tick_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (idle_c),
    .run  (run_c),
    .tick (cnt_en)
  );

  always_comb begin
    state_d       = state;
    minutes_d     = minutes;
    ovf_d         = ovf;
    lap_seconds_d = lap_seconds;
    lap_minutes_d = lap_minutes;
    lap_valid_d   = 1'b0;

    live    = is_active(state);
    at_max  = (minutes == MIN_W'(MAX_MIN));
    min_inc = at_max ? minutes : minutes + MIN_W'(1);

    case (state)
      IDLE: begin
        if (!clear && start_stop) state_d = RUN;
      end
      RUN: begin
        if (clear)                   state_d = IDLE;
        else if (sec_tick && at_max) state_d = OVF;
        else if (start_stop)         state_d = PAUSE;
      end
      PAUSE: begin
        if (clear)                   state_d = IDLE;
        else if (sec_tick && at_max) state_d = OVF;
        else if (start_stop)         state_d = RUN;
      end
      OVF: begin
        if (clear) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (live && !clear) begin
      if (sec_tick) begin
        minutes_d = min_inc;
        if (at_max) ovf_d = 1'b1;
      end
      // A lap on the wrap cycle reports the new minute to match seconds=0.
      if (lap) begin
        lap_seconds_d = seconds;
        lap_minutes_d = sec_tick ? min_inc : minutes;
        lap_valid_d   = 1'b1;
      end
    end

    if (state_d == IDLE) begin
      minutes_d = '0;
      ovf_d     = 1'b0;
    end

    idle_c = (state_d == IDLE);
    run_c  = (state == RUN) && (state_d == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      minutes     <= '0;
      ovf         <= 1'b0;
      lap_seconds <= '0;
      lap_minutes <= '0;
      lap_valid   <= 1'b0;
      running     <= 1'b0;
      cnt_rst_n   <= 1'b0;
    end else begin
      state       <= state_d;
      minutes     <= minutes_d;
      ovf         <= ovf_d;
      lap_seconds <= lap_seconds_d;
      lap_minutes <= lap_minutes_d;
      lap_valid   <= lap_valid_d;
      running     <= (state_d == RUN);
      cnt_rst_n   <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: a seconds-counter model drives the DUT, and a
// behavioural stopwatch model feeds per-cycle expectations to a monitor.
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned MIN_W   = 8;
  localparam int          MAX_MIN = 4;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_OVF = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_stop = 1'b0, clear = 1'b0, lap = 1'b0;
  logic [SEC_W-1:0] seconds;
  logic             sec_tick;
  logic             cnt_en, cnt_rst_n, lap_valid, running, ovf;
  logic [MIN_W-1:0] minutes, lap_minutes;
  logic [SEC_W-1:0] lap_seconds;

  int checks = 0;
  int failures = 0;
  int en_seen = 0;

  typedef struct {
    int cnt_en, running, cnt_rst_n, ovf, lap_valid, minutes, lap_s, lap_m;
  } exp_t;
  exp_t exp_q[$];

  // Behavioural model state: values the DUT outputs/counter hold right now.
  int m_mode, m_frac, m_cnt_en, m_secs, m_stick, m_min, m_ovf;
  int m_lap_valid, m_lap_s, m_lap_m;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.CLK_DIV(CLK_DIV), .MIN_W(MIN_W), .MAX_MIN(MAX_MIN)) dut (
    .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear), .lap(lap),
    .seconds(seconds), .sec_tick(sec_tick), .cnt_en(cnt_en),
    .cnt_rst_n(cnt_rst_n), .minutes(minutes), .lap_seconds(lap_seconds),
    .lap_minutes(lap_minutes), .lap_valid(lap_valid), .running(running),
    .ovf(ovf)
  );

  // The 0-59 seconds counter the controller sequences.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seconds  <= '0;
      sec_tick <= 1'b0;
    end else if (!cnt_rst_n) begin
      seconds  <= '0;
      sec_tick <= 1'b0;
    end else if (cnt_en) begin
      if (seconds == SEC_W'(SEC_MAX)) begin
        seconds  <= '0;
        sec_tick <= 1'b1;
      end else begin
        seconds  <= seconds + SEC_W'(1);
        sec_tick <= 1'b0;
      end
    end else begin
      sec_tick <= 1'b0;
    end
  end

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_frac = 0; m_cnt_en = 0; m_secs = 0; m_stick = 0;
    m_min = 0; m_ovf = 0; m_lap_valid = 0; m_lap_s = 0; m_lap_m = 0;
  endtask

  task automatic model_step(input bit ss, input bit clr, input bit lp);
    int n_mode, n_secs, n_stick, n_cnt_en;
    bit live, advance;
    live = (m_mode == M_RUN) || (m_mode == M_PAUSE);
    if (clr)                                  n_mode = M_IDLE;
    else if (live && m_stick && m_min == MAX_MIN) n_mode = M_OVF;
    else if (ss && m_mode == M_IDLE)          n_mode = M_RUN;
    else if (ss && m_mode == M_RUN)           n_mode = M_PAUSE;
    else if (ss && m_mode == M_PAUSE)         n_mode = M_RUN;
    else                                      n_mode = m_mode;

    m_lap_valid = 0;
    if (live && lp && !clr) begin
      m_lap_s = m_secs;
      m_lap_m = m_stick ? ((m_min < MAX_MIN) ? m_min + 1 : MAX_MIN) : m_min;
      m_lap_valid = 1;
    end

    if (m_mode == M_IDLE) begin
      n_secs = 0; n_stick = 0;
    end else if (m_cnt_en != 0) begin
      n_stick = (m_secs == 59) ? 1 : 0;
      n_secs  = (m_secs + 1) % 60;
    end else begin
      n_secs = m_secs; n_stick = 0;
    end

    advance  = (m_mode == M_RUN) && (n_mode == M_RUN);
    n_cnt_en = (advance && m_frac == CLK_DIV - 1) ? 1 : 0;
    if (n_mode == M_IDLE) m_frac = 0;
    else if (advance)     m_frac = (m_frac + 1) % CLK_DIV;

    if (n_mode == M_IDLE) m_min = 0;
    else if (live && !clr && m_stick != 0 && m_min < MAX_MIN) m_min = m_min + 1;

    m_mode = n_mode; m_secs = n_secs; m_stick = n_stick; m_cnt_en = n_cnt_en;
    m_ovf  = (n_mode == M_OVF) ? 1 : 0;
  endtask

  task automatic step(input bit r, input bit ss, input bit clr, input bit lp);
    exp_t e;
    @(negedge clk);
    #1;
    rst = r; start_stop = ss; clear = clr; lap = lp;
    if (r) model_reset();
    else   model_step(ss, clr, lp);
    e.cnt_en    = m_cnt_en;
    e.running   = (m_mode == M_RUN) ? 1 : 0;
    e.cnt_rst_n = (m_mode != M_IDLE) ? 1 : 0;
    e.ovf       = m_ovf;
    e.lap_valid = m_lap_valid;
    e.minutes   = m_min;
    e.lap_s     = m_lap_s;
    e.lap_m     = m_lap_m;
    exp_q.push_back(e);
    if (r) begin
      #1;
      check("rst_async_minutes",   int'(minutes),   0);
      check("rst_async_running",   int'(running),   0);
      check("rst_async_cnt_rst_n", int'(cnt_rst_n), 0);
      check("rst_async_cnt_en",    int'(cnt_en),    0);
    end
  endtask

  // Monitor: compares DUT outputs against the oldest queued expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (cnt_en === 1'b1) en_seen++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("cnt_en",      int'(cnt_en),      e.cnt_en);
        check("running",     int'(running),     e.running);
        check("cnt_rst_n",   int'(cnt_rst_n),   e.cnt_rst_n);
        check("ovf",         int'(ovf),         e.ovf);
        check("minutes",     int'(minutes),     e.minutes);
        check("lap_valid",   int'(lap_valid),   e.lap_valid);
        check("lap_seconds", int'(lap_seconds), e.lap_s);
        check("lap_minutes", int'(lap_minutes), e.lap_m);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int en_base;
    bit hit, done, rs, ss, cl, lp;
    model_reset();
    repeat (3) step(1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0);

    // One full minute from a fresh start.
    en_base = en_seen;
    step(0, 1, 0, 0);
    repeat (243) step(0, 0, 0, 0);
    check("pulses_in_60s", en_seen - en_base, 60);
    check("minute_after_60s", int'(minutes), 1);
    check("seconds_after_60s", int'(seconds), 0);

    // Pause two cycles into a second, hold, resume.
    for (int i = 0; i < 50 && !(m_mode == M_RUN && m_frac == 2); i++) step(0, 0, 0, 0);
    check("pause_point_reached", (m_mode == M_RUN && m_frac == 2) ? 1 : 0, 1);
    step(0, 1, 0, 0);
    en_base = en_seen;
    repeat (20) step(0, 0, 0, 0);
    check("no_pulse_in_pause", en_seen - en_base, 0);
    step(0, 1, 0, 0);
    repeat (4) step(0, 0, 0, 0);

    // Lap on the same cycle as the 3:59 -> 4:00 wrap.
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      hit = (m_mode == M_RUN && m_min == 3 && m_stick != 0);
      step(0, 0, 0, hit);
      done = hit;
    end
    check("lap_wrap_reached", int'(done), 1);
    step(0, 0, 0, 0);
    check("lap_wrap_valid", int'(lap_valid), 1);
    check("lap_wrap_minutes", int'(lap_minutes), 4);
    check("lap_wrap_seconds", int'(lap_seconds), 0);
    step(0, 0, 0, 0);
    check("lap_valid_one_cycle", int'(lap_valid), 0);

    // Run into overflow, poke ignored commands, then clear.
    for (int i = 0; i < 1500 && m_mode != M_OVF; i++) step(0, 0, 0, 0);
    check("ovf_reached", (m_mode == M_OVF) ? 1 : 0, 1);
    step(0, 0, 0, 0);
    check("ovf_flag", int'(ovf), 1);
    check("ovf_minutes", int'(minutes), MAX_MIN);
    en_base = en_seen;
    repeat (3) begin
      step(0, 1, 0, 1);
      repeat (4) step(0, 0, 0, 0);
    end
    check("ovf_no_pulse", en_seen - en_base, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    check("clear_ovf", int'(ovf), 0);
    check("clear_cnt_rst_n", int'(cnt_rst_n), 0);

    // clear and start_stop together while running.
    step(0, 1, 0, 0);
    repeat (7) step(0, 0, 0, 0);
    step(0, 1, 1, 0);
    step(0, 0, 0, 0);
    check("clr_ss_running", int'(running), 0);
    check("clr_ss_minutes", int'(minutes), 0);

    // Reset asserted mid-run at two minutes.
    step(0, 1, 0, 0);
    for (int i = 0; i < 800 && m_min != 2; i++) step(0, 0, 0, 0);
    check("two_min_reached", m_min, 2);
    repeat (5) step(0, 0, 0, 0);
    repeat (3) step(1, 0, 0, 0);
    repeat (6) step(0, 0, 0, 0);

    // Randomized commands.
    for (int i = 0; i < 5000; i++) begin
      rs = ($urandom_range(0, 1499) == 0);
      ss = ($urandom_range(0, 24) == 0);
      cl = ($urandom_range(0, 199) == 0);
      lp = ($urandom_range(0, 9) == 0);
      step(rs, ss, cl, lp);
    end

    repeat (3) step(0, 0, 0, 0);
    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
